// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 serial receiver: register map, frame size, FSM states.
package max7219_pkg;

    localparam int unsigned FRAME_BITS = 16;

    localparam logic [3:0] ADDR_NOOP       = 4'h0;
    localparam logic [3:0] ADDR_DIGIT0     = 4'h1;
    localparam logic [3:0] ADDR_DIGIT1     = 4'h2;
    localparam logic [3:0] ADDR_DIGIT2     = 4'h3;
    localparam logic [3:0] ADDR_DIGIT3     = 4'h4;
    localparam logic [3:0] ADDR_DIGIT4     = 4'h5;
    localparam logic [3:0] ADDR_DIGIT5     = 4'h6;
    localparam logic [3:0] ADDR_DIGIT6     = 4'h7;
    localparam logic [3:0] ADDR_DIGIT7     = 4'h8;
    localparam logic [3:0] ADDR_DECODE     = 4'h9;
    localparam logic [3:0] ADDR_INTENSITY  = 4'hA;
    localparam logic [3:0] ADDR_SCAN_LIMIT = 4'hB;
    localparam logic [3:0] ADDR_SHUTDOWN   = 4'hC;
    localparam logic [3:0] ADDR_TEST       = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } rx_state_t;

endpackage

// File: rtl/max7219_receiver_if.sv
// Serial link between a MAX7219 driver (master) and the receiver model (slave).
interface max7219_receiver_if;
    logic sck;
    logic mosi;
    logic cs;

    modport master (output sck, output mosi, output cs);
    modport slave  (input  sck, input  mosi, input  cs);
endinterface

// File: rtl/max7219_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin with registered-level edge strobes.
// All flops reset to 0, so a pin already high at reset shows up as a rise.
module max7219_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Synchroniser chain plus one delayed copy of its output for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  =  r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[SYNC_STAGES-1] &  r_prev;

endmodule

// File: rtl/max7219_receiver.sv
// MAX7219 serial receiver: synchronises sck/mosi/cs, assembles 16-bit frames and
// decodes them into the digit/control register file.
// Optional feature macro MAX7219_RX_DOUT_EN: adds daisy-chain output dout and
// accepts over-long frames (last 16 bits kept); otherwise over-long frames are errors.
module max7219_receiver
    import max7219_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    max7219_receiver_if.slave        link,
    output logic [63:0]              pixels,
    output logic [7:0]               decode_mode,
    output logic [3:0]               intensity,
    output logic [2:0]               scan_limit,
    output logic                     shutdown,
    output logic                     display_test,
    output logic                     frame_valid,
    output logic                     frame_err,
    output logic [3:0]               last_addr,
    output logic [7:0]               last_data
`ifdef MAX7219_RX_DOUT_EN
    ,
    output logic                     dout
`endif
);

    localparam logic [4:0] FRAME_CNT = 5'(FRAME_BITS);

    logic                   w_sck_level, w_sck_rise, w_sck_fall;
    logic                   w_cs_level, w_cs_rise, w_cs_fall;
    logic                   w_mosi;
    logic [3:0]             w_addr;
    logic [7:0]             w_data;
    logic                   w_accept;
    logic                   w_unused;

    logic [SYNC_STAGES-1:0] r_mosi_sync;
    rx_state_t              r_state;
    logic [FRAME_BITS-1:0]  r_sr;
    logic [4:0]             r_bit_cnt;
    logic [63:0]            r_pixels;
    logic [7:0]             r_decode;
    logic [3:0]             r_intensity;
    logic [2:0]             r_scan_limit;
    logic                   r_shutdown;
    logic                   r_test;
    logic                   r_frame_valid;
    logic                   r_frame_err;
    logic [3:0]             r_last_addr;
    logic [7:0]             r_last_data;

    max7219_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .clk     (clk),
        .rst     (rst),
        .i_async (link.sck),
        .o_level (w_sck_level),
        .o_rise  (w_sck_rise),
        .o_fall  (w_sck_fall)
    );

    max7219_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk     (clk),
        .rst     (rst),
        .i_async (link.cs),
        .o_level (w_cs_level),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    // mosi only needs a level, delayed by the same depth as sck so they stay aligned
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mosi_sync <= '0;
        end else begin
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], link.mosi};
        end
    end

    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
    assign w_addr = r_sr[11:8];
    assign w_data = r_sr[7:0];

`ifdef MAX7219_RX_DOUT_EN
    assign w_accept = (r_bit_cnt >= FRAME_CNT);
`else
    assign w_accept = (r_bit_cnt == FRAME_CNT);
`endif

    assign w_unused = ^{r_sr[FRAME_BITS-1:12], w_sck_fall, w_sck_level, w_cs_level};

    // Frame FSM: shift while cs is low, then commit or reject the frame for one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_sr          <= '0;
            r_bit_cnt     <= '0;
            r_pixels      <= '0;
            r_decode      <= '0;
            r_intensity   <= '0;
            r_scan_limit  <= '0;
            r_shutdown    <= 1'b1;
            r_test        <= 1'b0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            r_last_addr   <= '0;
            r_last_data   <= '0;
        end else begin
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_cs_fall) begin
                        r_state   <= ST_SHIFT;
                        r_sr      <= '0;
                        r_bit_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    // a cs rise in the same cycle as an sck rise ends the frame unshifted
                    if (w_cs_rise) begin
                        r_state <= ST_COMMIT;
                    end else if (w_sck_rise) begin
                        r_sr <= {r_sr[FRAME_BITS-2:0], w_mosi};
                        if (r_bit_cnt != '1) begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end
                end
                ST_COMMIT: begin
                    r_state <= ST_IDLE;
                    if (w_accept) begin
                        r_frame_valid <= 1'b1;
                        r_last_addr   <= w_addr;
                        r_last_data   <= w_data;
                        for (int unsigned d = 0; d < 8; d++) begin
                            if (w_addr == 4'(ADDR_DIGIT0 + d)) begin
                                r_pixels[(7 - d) * 8 +: 8] <= w_data;
                            end
                        end
                        case (w_addr)
                            ADDR_DECODE:     r_decode     <= w_data;
                            ADDR_INTENSITY:  r_intensity  <= w_data[3:0];
                            ADDR_SCAN_LIMIT: r_scan_limit <= w_data[2:0];
                            ADDR_SHUTDOWN:   r_shutdown   <= ~w_data[0];
                            ADDR_TEST:       r_test       <= w_data[0];
                            default: ;
                        endcase
                    end else begin
                        r_frame_err <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef MAX7219_RX_DOUT_EN
    logic r_dout;

    // Daisy-chain output: the bit falling off the top of the shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout <= 1'b0;
        end else if (w_sck_fall) begin
            r_dout <= r_sr[FRAME_BITS-1];
        end
    end

    assign dout = r_dout;
`endif

    assign pixels       = r_pixels;
    assign decode_mode  = r_decode;
    assign intensity    = r_intensity;
    assign scan_limit   = r_scan_limit;
    assign shutdown     = r_shutdown;
    assign display_test = r_test;
    assign frame_valid  = r_frame_valid;
    assign frame_err    = r_frame_err;
    assign last_addr    = r_last_addr;
    assign last_data    = r_last_data;

endmodule

// File: tb/tb_max7219_receiver.sv
// Bench for max7219_receiver: directed sequences, a vector table and random frames,
// checked against an address-indexed register model.
module tb_max7219_receiver;

    localparam int S = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    max7219_receiver_if link();

    logic [63:0] pixels;
    logic [7:0]  decode_mode;
    logic [3:0]  intensity;
    logic [2:0]  scan_limit;
    logic        shutdown, display_test, frame_valid, frame_err;
    logic [3:0]  last_addr;
    logic [7:0]  last_data;
`ifdef MAX7219_RX_DOUT_EN
    logic        dout;
    localparam bit DOUT_EN = 1'b1;
`else
    localparam bit DOUT_EN = 1'b0;
`endif

    max7219_receiver #(.SYNC_STAGES(S)) dut (
        .clk          (clk),
        .rst          (rst),
        .link         (link.slave),
        .pixels       (pixels),
        .decode_mode  (decode_mode),
        .intensity    (intensity),
        .scan_limit   (scan_limit),
        .shutdown     (shutdown),
        .display_test (display_test),
        .frame_valid  (frame_valid),
        .frame_err    (frame_err),
        .last_addr    (last_addr),
        .last_data    (last_data)
`ifdef MAX7219_RX_DOUT_EN
        ,
        .dout         (dout)
`endif
    );

    int checks = 0;
    int failures = 0;

    // reference model: register contents indexed by frame address
    logic [7:0] m_reg [16];
    logic [3:0] m_last_addr;
    logic [7:0] m_last_data;

    int   n_valid, n_err, n_both, lat, total_valid;
    logic dout_hist [32];

    typedef struct {
        logic [31:0] bits;
        int          n;
        logic        exp_v;
        logic        exp_e;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int a = 0; a < 16; a++) m_reg[a] = 8'h00;
        m_last_addr = 4'h0;
        m_last_data = 8'h00;
    endtask

    task automatic model_frame(input logic [31:0] bits, input int n, output logic ev, output logic ee);
        logic [15:0] w;
        w = bits[15:0];
        if (n == 16 || (DOUT_EN && n > 16)) begin
            m_reg[w[11:8]] = w[7:0];
            m_last_addr    = w[11:8];
            m_last_data    = w[7:0];
            ev = 1'b1;
            ee = 1'b0;
        end else begin
            ev = 1'b0;
            ee = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " pixels"}, pixels, {m_reg[1], m_reg[2], m_reg[3], m_reg[4],
                                       m_reg[5], m_reg[6], m_reg[7], m_reg[8]});
        chk({tag, " decode_mode"}, decode_mode, m_reg[9]);
        chk({tag, " intensity"}, intensity, m_reg[10][3:0]);
        chk({tag, " scan_limit"}, scan_limit, m_reg[11][2:0]);
        chk({tag, " shutdown"}, shutdown, {63'd0, ~m_reg[12][0]});
        chk({tag, " display_test"}, display_test, {63'd0, m_reg[15][0]});
        chk({tag, " last_addr"}, last_addr, m_last_addr);
        chk({tag, " last_data"}, last_data, m_last_data);
    endtask

    // watch a bounded window after cs rise for the commit/error pulse
    task automatic observe();
        n_valid = 0;
        n_err   = 0;
        lat     = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (frame_valid) begin n_valid++; lat = c; end
            if (frame_err)   begin n_err++;   lat = c; end
            if (frame_valid && frame_err) n_both++;
        end
        total_valid += n_valid;
    endtask

    task automatic shift_bit(input logic b, input int idx);
        link.mosi = b;
        repeat (3) @(negedge clk);
        link.sck = 1'b1;
        repeat (3) @(negedge clk);
        link.sck = 1'b0;
        repeat (3) @(negedge clk);
`ifdef MAX7219_RX_DOUT_EN
        dout_hist[idx] = dout;
`else
        dout_hist[idx] = 1'b0;
`endif
    endtask

    task automatic send_frame(input logic [31:0] bits, input int n);
        link.cs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = n - 1; i >= 0; i--) shift_bit(bits[i], n - 1 - i);
        link.cs = 1'b1;
        observe();
    endtask

    task automatic apply(input logic [31:0] bits, input int n, input string tag);
        logic ev, ee;
        model_frame(bits, n, ev, ee);
        send_frame(bits, n);
        chk({tag, " valid"}, 64'(n_valid), {63'd0, ev});
        chk({tag, " err"}, 64'(n_err), {63'd0, ee});
        chk({tag, " latency"}, 64'(lat), 64'(S + 2));
        check_all(tag);
    endtask

    initial begin
        link.sck  = 1'b0;
        link.mosi = 1'b0;
        link.cs   = 1'b1;
        n_both = 0;
        total_valid = 0;
        model_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_all("reset");
        chk("reset frame_valid", frame_valid, 0);
        chk("reset frame_err", frame_err, 0);

        // single intensity frame
        apply(32'h0A0B, 16, "t2");
        chk("t2 intensity", intensity, 4'hB);
        chk("t2 last_addr", last_addr, 4'hA);
        chk("t2 last_data", last_data, 8'h0B);

        // short frame rejected, then a digit write
        apply(32'h0155, 15, "t3short");
        apply(32'h0155, 16, "t3");
        chk("t3 digit0", pixels[63:56], 8'h55);

        // over-long frame
        apply(32'h0001_0C01, 17, "t4");
`ifdef MAX7219_RX_DOUT_EN
        chk("t4 shutdown", shutdown, 0);
        chk("t4 dout 15th fall", dout_hist[14], 0);
        chk("t4 dout 16th fall", dout_hist[15], 1);
`else
        chk("t4 shutdown", shutdown, 1);
        chk("t4 frame_err", n_err, 1);
`endif

        // reset in the middle of a frame
        link.cs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 15; i >= 8; i--) shift_bit(1'(32'h0F01 >> i), 15 - i);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_all("t5rst");
        link.cs = 1'b1;
        observe();
        chk("t5 idle cs rise valid", n_valid, 0);
        chk("t5 idle cs rise err", n_err, 0);
        apply(32'h0F01, 16, "t5");
        chk("t5 display_test", display_test, 1);

        // sck activity while deselected, then a no-op frame
        for (int k = 0; k < 5; k++) begin
            link.mosi = k[0];
            repeat (3) @(negedge clk);
            link.sck = 1'b1;
            repeat (3) @(negedge clk);
            link.sck = 1'b0;
        end
        observe();
        chk("t6 idle sck valid", n_valid, 0);
        chk("t6 idle sck err", n_err, 0);
        apply(32'h00FF, 16, "t6");
        chk("t6 last_data", last_data, 8'hFF);

        // cs rise coincident with an sck rise: that edge must not be shifted
        begin
            logic ev, ee;
            model_frame(32'h0A05, 16, ev, ee);
            link.cs = 1'b0;
            repeat (4) @(negedge clk);
            for (int i = 15; i >= 0; i--) shift_bit(1'(32'h0A05 >> i), 15 - i);
            link.mosi = 1'b1;
            repeat (3) @(negedge clk);
            link.sck = 1'b1;
            link.cs  = 1'b1;
            observe();
            link.sck = 1'b0;
            repeat (4) @(negedge clk);
            chk("race valid", n_valid, {63'd0, ev});
            chk("race intensity", intensity, 4'h5);
            check_all("race");
        end

        // full display load as the driver would send it
        total_valid = 0;
        apply(32'h0B07, 16, "lb scan");
        apply(32'h0C01, 16, "lb shut");
        for (int d = 1; d <= 8; d++) apply(32'(d * 256 + d), 16, $sformatf("lb dig%0d", d));
        chk("lb pixels", pixels, 64'h0102030405060708);
        chk("lb shutdown", shutdown, 0);
        chk("lb scan_limit", scan_limit, 3'd7);
        chk("lb frame count", total_valid, 10);

        // vector table
        tbl[0] = '{32'h0932, 16, 1'b1, 1'b0};
        tbl[1] = '{32'h0D33, 16, 1'b1, 1'b0};
        tbl[2] = '{32'h0E44, 16, 1'b1, 1'b0};
        tbl[3] = '{32'h5F01, 16, 1'b1, 1'b0};
        tbl[4] = '{32'h0F00, 16, 1'b1, 1'b0};
        tbl[5] = '{32'h0AFF, 15, 1'b0, 1'b1};
        tbl[6] = '{32'h0000, 16, 1'b1, 1'b0};
        tbl[7] = '{32'h08AA, 16, 1'b1, 1'b0};
        tbl[8] = '{32'h0C00, 16, 1'b1, 1'b0};
`ifdef MAX7219_RX_DOUT_EN
        tbl[9] = '{32'h0003_0B03, 18, 1'b1, 1'b0};
`else
        tbl[9] = '{32'h0003_0B03, 18, 1'b0, 1'b1};
`endif
        for (int i = 0; i < 10; i++) begin
            apply(tbl[i].bits, tbl[i].n, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d table valid", i), n_valid, {63'd0, tbl[i].exp_v});
            chk($sformatf("tbl%0d table err", i), n_err, {63'd0, tbl[i].exp_e});
        end

        // random frames, including short and over-long ones
        for (int k = 0; k < 40; k++) begin
            logic [31:0] b;
            int n;
            b = $urandom;
            case ($urandom_range(0, 5))
                0:       n = 15;
                1:       n = 17;
                2:       n = 20;
                default: n = 16;
            endcase
            apply(b, n, $sformatf("rand%0d", k));
        end

        chk("valid/err exclusive", n_both, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
